// File: rtl/rs232_tx_sched.sv
// Shares one RS232 transmitter between NREQ byte sources (round-robin, optional packet lock).
// Latency: valid on an idle transmitter -> tx_start one cycle later; one byte per frame.
// Backpressure: req_ready pulses only on the capture cycle; sources hold valid until served.
module rs232_tx_sched #(
    parameter int NREQ    = 3,
    parameter int LOCK_TO = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_en,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    input  logic [NREQ-1:0]     req_fsel,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     grant,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic                tx_fsel,
    input  logic                tx_rdy,
    output logic                busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LOCK_TO + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic            lock;
    logic [CW-1:0]   lock_cnt;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] cand;
    logic [PW-1:0]   win_idx;
    logic            win_found;
    logic [NREQ-1:0] win_oh;
    logic            capture;
    logic            owner_valid;

    // While locked only the previous owner may be served; otherwise everyone competes.
    assign eligible    = lock ? grant : {NREQ{1'b1}};
    assign cand        = req_valid & eligible;
    assign owner_valid = |(req_valid & grant);

    // Round-robin scan: first candidate strictly after the last winner, wrapping.
    always_comb begin : arb_scan
        int            idx;
        logic [PW-1:0] ti;
        idx       = 0;
        ti        = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            ti = PW'(idx);
            if (!win_found && cand[ti]) begin
                win_found = 1'b1;
                win_idx   = ti;
            end
        end
    end

    // Capture is only possible while idle with the transmitter ready; never during reset.
    assign win_oh    = NREQ'(1) << win_idx;
    assign capture   = (state == IDLE) && tx_rdy && win_found && !rst;
    assign req_ready = capture ? win_oh : '0;
    assign tx_start  = (state == ISSUE);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake sequencing: start held until the transmitter's enable strobe, then track rdy.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (capture) state_nxt = ISSUE;
            ISSUE:     if (tx_en)   state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!tx_rdy) state_nxt = WAIT_DONE;
            WAIT_DONE: if (tx_rdy)  state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Byte latch, ownership, round-robin pointer and packet-lock timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data  <= 8'h00;
            tx_fsel  <= 1'b0;
            grant    <= '0;
            rr_ptr   <= PW'(NREQ - 1);
            lock     <= 1'b0;
            lock_cnt <= '0;
        end else if (capture) begin
            tx_data  <= req_data[{win_idx, 3'b000} +: 8];
            tx_fsel  <= req_fsel[win_idx];
            grant    <= win_oh;
            rr_ptr   <= win_idx;
            lock     <= ~req_last[win_idx];
            lock_cnt <= '0;
        end else if ((state == IDLE) && lock && !owner_valid) begin
            if (lock_cnt != CW'(LOCK_TO)) begin
                lock_cnt <= lock_cnt + 1'b1;
            end
            // The release takes effect next cycle, so nobody else is captured on this one.
            if (int'(lock_cnt) + 1 >= LOCK_TO) begin
                lock <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs232_tx_sched.sv
module tb_rs232_tx_sched;

    localparam int NREQ    = 3;
    localparam int LOCK_TO = 4;
    localparam int NCYC    = 6000;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_en;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_fsel;
    logic [2:0]  req_ready;
    logic [2:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_fsel;
    logic        tx_rdy;
    logic        busy;

    always #5 clk = ~clk;

    rs232_tx_sched #(.NREQ(NREQ), .LOCK_TO(LOCK_TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_en     (tx_en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_fsel  (req_fsel),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_fsel   (tx_fsel),
        .tx_rdy    (tx_rdy),
        .busy      (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-source pending byte
    bit       has_b  [NREQ];
    logic [7:0] b_data [NREQ];
    bit       b_last [NREQ];
    bit       b_fsel [NREQ];

    // Reference model: transaction-level view of the scheduler
    int        m_phase;     // 0 free, 1 byte handed over, 2 frame in flight
    bit        m_issue;     // start request outstanding
    int        m_last_win;
    bit        m_lock;
    int        m_owner;
    int        m_stall;
    logic [7:0] m_data;
    bit        m_fsel;
    logic [2:0] m_grant;
    int        captures;
    int        starts;

    task automatic model_reset();
        m_phase    = 0;
        m_issue    = 0;
        m_last_win = NREQ - 1;
        m_lock     = 0;
        m_owner    = 0;
        m_stall    = 0;
        m_data     = 8'h00;
        m_fsel     = 0;
        m_grant    = 3'b000;
    endtask

    initial begin
        int         win;
        int         idx;
        logic [2:0] exp_ready;
        bit         free;
        bit         start_ev;
        bit         rdy_n;
        bit         rst_n;
        bit         want_rst;
        bit         t_busy;
        int         t_ticks;
        bit         gen;

        captures = 0;
        starts   = 0;
        want_rst = 0;
        t_busy   = 0;
        t_ticks  = 0;
        model_reset();

        rst       = 1'b1;
        tx_en     = 1'b0;
        tx_rdy    = 1'b1;
        req_valid = 3'b000;
        req_data  = 24'h0;
        req_last  = 3'b000;
        req_fsel  = 3'b000;
        for (int i = 0; i < NREQ; i++) begin
            has_b[i]  = 0;
            b_data[i] = 8'h00;
            b_last[i] = 1;
            b_fsel[i] = 0;
        end
        has_b[0]  = 1;
        b_data[0] = 8'h55;
        b_last[0] = 1;
        b_fsel[0] = 0;

        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        tx_en     = 1'b1;
        req_valid = 3'b001;
        req_data  = 24'h000055;
        req_last  = 3'b001;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);

            // Directed opening: reset values and the first single-source transfer
            if (cyc == 0) begin
                chk("rst_grant", grant, 3'b000);
                chk("rst_busy", busy, 1'b0);
                chk("rst_tx_start", tx_start, 1'b0);
                chk("rst_tx_data", tx_data, 8'h00);
                chk("rst_tx_fsel", tx_fsel, 1'b0);
                chk("t1_ready", req_ready, 3'b001);
            end
            if (cyc == 1) begin
                chk("t1_start", tx_start, 1'b1);
                chk("t1_data", tx_data, 8'h55);
                chk("t1_grant", grant, 3'b001);
            end

            // Expected winner this cycle
            free      = (m_phase == 0);
            win       = -1;
            exp_ready = 3'b000;
            if (!rst && free && tx_rdy) begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_last_win + k) % NREQ;
                    if (win < 0 && req_valid[idx] && (!m_lock || idx == m_owner)) begin
                        win = idx;
                    end
                end
            end
            if (win >= 0) exp_ready = 3'(1 << win);

            chk("req_ready", req_ready, exp_ready);
            chk("tx_start", tx_start, m_issue);
            chk("busy", busy, (m_phase != 0));
            chk("grant", grant, m_grant);
            chk("tx_data", tx_data, m_data);
            chk("tx_fsel", tx_fsel, m_fsel);

            // Transmitter behaviour
            rdy_n    = tx_rdy;
            start_ev = tx_start && tx_en && !t_busy;
            if (start_ev) begin
                starts++;
                chk("start_once", starts, captures);
                t_busy  = 1;
                t_ticks = $urandom_range(3, 6);
                rdy_n   = 0;
            end else if (t_busy && tx_en) begin
                t_ticks--;
                if (t_ticks == 0) begin
                    t_busy = 0;
                    rdy_n  = 1;
                end
            end

            // Occasional reset while a frame is on the wire
            if ((cyc % 700) == 350) want_rst = 1;
            rst_n = 0;
            if (want_rst && m_phase == 2 && !rst) begin
                rst_n    = 1;
                want_rst = 0;
            end

            // Advance the model
            if (rst) begin
                model_reset();
            end else begin
                if (m_phase == 2 && tx_rdy) m_phase = 0;
                else if (m_phase == 1 && !m_issue && !tx_rdy) m_phase = 2;
                if (m_issue && tx_en) m_issue = 0;
                if (win >= 0) begin
                    captures++;
                    m_phase    = 1;
                    m_issue    = 1;
                    m_data     = b_data[win];
                    m_fsel     = b_fsel[win];
                    m_grant    = 3'(1 << win);
                    m_last_win = win;
                    m_owner    = win;
                    m_lock     = !b_last[win];
                    m_stall    = 0;
                    has_b[win] = 0;
                end else if (free && m_lock && !req_valid[m_owner]) begin
                    m_stall++;
                    if (m_stall >= LOCK_TO) m_lock = 0;
                end
            end

            // Drive next cycle
            @(posedge clk);
            #1;
            rst    = rst_n;
            tx_rdy = rdy_n;
            tx_en  = (cyc < NCYC / 2) ? ($urandom_range(0, 1) == 1) : ((cyc % 4) == 3);
            gen    = (cyc >= 20) && (cyc < NCYC - 200);
            for (int i = 0; i < NREQ; i++) begin
                if (!has_b[i] && gen && $urandom_range(0, 3) == 0) begin
                    has_b[i]  = 1;
                    b_data[i] = 8'($urandom);
                    b_last[i] = ($urandom_range(0, 99) < 60);
                    b_fsel[i] = ($urandom_range(0, 1) == 1);
                end
                req_valid[i]       = has_b[i] && ((cyc < 20) || ($urandom_range(0, 99) < 75));
                req_data[8*i +: 8] = b_data[i];
                req_last[i]        = b_last[i];
                req_fsel[i]        = b_fsel[i];
            end
        end

        @(negedge clk);
        chk("drain_idle", busy, 1'b0);
        chk("starts_eq_caps", starts, captures);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
